// File: rtl/vga_dac_host_fml_pkg.sv
// rtl/vga_dac_host_fml_pkg.sv - shared constants and FSM encoding for the DAC host initiator
package vga_dac_host_fml_pkg;

    localparam logic [1:0] SEL_PEL_MASK = 2'd0;
    localparam logic [1:0] SEL_RD_IDX   = 2'd1;
    localparam logic [1:0] SEL_WR_IDX   = 2'd2;
    localparam logic [1:0] SEL_DATA     = 2'd3;

    localparam logic [1:0] CYC_R = 2'd0;
    localparam logic [1:0] CYC_G = 2'd1;
    localparam logic [1:0] CYC_B = 2'd2;

    localparam logic [1:0] DAC_STATE_WR = 2'b00;
    localparam logic [1:0] DAC_STATE_RD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_ACK     = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/vga_dac_rgb_seq.sv
// rtl/vga_dac_rgb_seq.sv - R,G,B component counter with palette index auto-increment
module vga_dac_rgb_seq
    import vga_dac_host_fml_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_load_index,
    input  logic       i_advance,
    output logic [1:0] o_cycle,
    output logic [7:0] o_index
);

    logic [1:0] r_cycle;
    logic [7:0] r_index;

    // Load wins over advance; after B the index steps and wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= CYC_R;
            r_index <= 8'h00;
        end else if (i_load) begin
            r_cycle <= CYC_R;
            r_index <= i_load_index;
        end else if (i_advance) begin
            if (r_cycle == CYC_B) begin
                r_cycle <= CYC_R;
                r_index <= r_index + 8'h01;
            end else begin
                r_cycle <= r_cycle + 2'd1;
            end
        end
    end

    assign o_cycle = r_cycle;
    assign o_index = r_index;

endmodule

// File: rtl/vga_dac_host_fml.sv
// rtl/vga_dac_host_fml.sv - CPU port decoder and R,G,B sequencer driving the DAC colour registers
module vga_dac_host_fml
    import vga_dac_host_fml_pkg::*;
#(
    parameter int DATA_SHIFT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_stb,
    input  logic       io_we,
    input  logic [1:0] io_sel,
    input  logic [7:0] io_wdat,
    output logic [7:0] io_rdat,
    output logic       io_ack,
    output logic [7:0] pel_mask,
    output logic       dac_we,
    output logic [1:0] dac_write_data_cycle,
    output logic [7:0] dac_write_data_register,
    output logic [3:0] dac_write_data,
    output logic [1:0] dac_read_data_cycle,
    output logic [7:0] dac_read_data_register,
    input  logic [3:0] dac_read_data
);

    fsm_state_t r_state;
    fsm_state_t w_next_state;

    logic [7:0] r_pel_mask;
    logic [1:0] r_dac_state;
    logic [7:0] r_rdat;

    logic       w_access;
    logic       w_data_wr;
    logic       w_wr_load;
    logic       w_rd_load;
    logic       w_rd_advance;
    logic [7:0] w_rd_ext;
    logic [1:0] w_wr_cycle;
    logic [7:0] w_wr_index;
    logic [1:0] w_rd_cycle;
    logic [7:0] w_rd_index;

    assign w_access     = (r_state == ST_IDLE) && io_stb;
    assign w_data_wr    = w_access && io_we && (io_sel == SEL_DATA) && !rst;
    assign w_wr_load    = w_access && io_we && (io_sel == SEL_WR_IDX);
    assign w_rd_load    = w_access && io_we && (io_sel == SEL_RD_IDX);
    assign w_rd_advance = (r_state == ST_RD_WAIT);
    assign w_rd_ext     = 8'(dac_read_data) << DATA_SHIFT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (io_stb) begin
                    if (!io_we && (io_sel == SEL_DATA)) begin
                        w_next_state = ST_RD_WAIT;
                    end else begin
                        w_next_state = ST_ACK;
                    end
                end
            end
            ST_RD_WAIT: w_next_state = ST_ACK;
            ST_ACK:     w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Non-data reads are captured at decode; data reads wait one cycle for the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pel_mask  <= 8'hFF;
            r_dac_state <= DAC_STATE_WR;
            r_rdat      <= 8'h00;
        end else if (w_access) begin
            if (io_we) begin
                case (io_sel)
                    SEL_PEL_MASK: r_pel_mask  <= io_wdat;
                    SEL_RD_IDX:   r_dac_state <= DAC_STATE_RD;
                    SEL_WR_IDX:   r_dac_state <= DAC_STATE_WR;
                    default:      ;
                endcase
            end else begin
                case (io_sel)
                    SEL_PEL_MASK: r_rdat <= r_pel_mask;
                    SEL_RD_IDX:   r_rdat <= {6'b0, r_dac_state};
                    SEL_WR_IDX:   r_rdat <= w_wr_index;
                    default:      ;
                endcase
            end
        end else if (r_state == ST_RD_WAIT) begin
            r_rdat <= w_rd_ext;
        end
    end

    vga_dac_rgb_seq u_wr_seq (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_wr_load),
        .i_load_index (io_wdat),
        .i_advance    (w_data_wr),
        .o_cycle      (w_wr_cycle),
        .o_index      (w_wr_index)
    );

    vga_dac_rgb_seq u_rd_seq (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_rd_load),
        .i_load_index (io_wdat),
        .i_advance    (w_rd_advance),
        .o_cycle      (w_rd_cycle),
        .o_index      (w_rd_index)
    );

    assign io_ack                  = (r_state == ST_ACK);
    assign io_rdat                 = r_rdat;
    assign pel_mask                = r_pel_mask;
    assign dac_we                  = w_data_wr;
    assign dac_write_data          = w_data_wr ? io_wdat[DATA_SHIFT+3:DATA_SHIFT] : 4'h0;
    assign dac_write_data_cycle    = w_wr_cycle;
    assign dac_write_data_register = w_wr_index;
    assign dac_read_data_cycle     = w_rd_cycle;
    assign dac_read_data_register  = w_rd_index;

endmodule

// File: tb/tb_vga_dac_host_fml.sv
// tb/tb_vga_dac_host_fml.sv - scoreboard bench for the DAC host initiator
module tb_vga_dac_host_fml;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_stb;
    logic       io_we;
    logic [1:0] io_sel;
    logic [7:0] io_wdat;
    logic [7:0] io_rdat;
    logic       io_ack;
    logic [7:0] pel_mask;
    logic       dac_we;
    logic [1:0] dac_write_data_cycle;
    logic [7:0] dac_write_data_register;
    logic [3:0] dac_write_data;
    logic [1:0] dac_read_data_cycle;
    logic [7:0] dac_read_data_register;
    logic [3:0] dac_read_data = 4'h0;

    always #5 clk = ~clk;

    vga_dac_host_fml #(.DATA_SHIFT(2)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .io_stb                  (io_stb),
        .io_we                   (io_we),
        .io_sel                  (io_sel),
        .io_wdat                 (io_wdat),
        .io_rdat                 (io_rdat),
        .io_ack                  (io_ack),
        .pel_mask                (pel_mask),
        .dac_we                  (dac_we),
        .dac_write_data_cycle    (dac_write_data_cycle),
        .dac_write_data_register (dac_write_data_register),
        .dac_write_data          (dac_write_data),
        .dac_read_data_cycle     (dac_read_data_cycle),
        .dac_read_data_register  (dac_read_data_register),
        .dac_read_data           (dac_read_data)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Palette contents seen by the DUT; index 05h holds the A/5/3 triple.
    function automatic logic [3:0] pal_val(input logic [7:0] r, input logic [1:0] c);
        if (r == 8'h05) begin
            case (c)
                2'd0:    return 4'hA;
                2'd1:    return 4'h5;
                default: return 4'h3;
            endcase
        end
        return 4'((int'(r) * 3 + int'(c)) ^ 9);
    endfunction

    always @(posedge clk) dac_read_data <= pal_val(dac_read_data_register, dac_read_data_cycle);

    typedef struct {
        logic [7:0] r;
        logic [1:0] c;
        logic [3:0] d;
    } wr_t;

    wr_t        wq[$];
    logic [7:0] rq[$];
    wr_t        mon_e;

    logic [7:0] m_pel, m_wr_reg, m_rd_reg;
    logic [1:0] m_wr_cyc, m_rd_cyc, m_state;

    task automatic model_reset();
        m_pel    = 8'hFF;
        m_wr_reg = 8'h00;
        m_rd_reg = 8'h00;
        m_wr_cyc = 2'd0;
        m_rd_cyc = 2'd0;
        m_state  = 2'b00;
    endtask

    always @(negedge clk) begin
        if (dac_we) begin
            if (wq.size() == 0) begin
                check("dac_we_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = wq.pop_front();
                check("we_reg",  dac_write_data_register, mon_e.r);
                check("we_cyc",  dac_write_data_cycle,    mon_e.c);
                check("we_data", dac_write_data,          mon_e.d);
            end
        end
    end

    task automatic access(input logic we, input logic [1:0] sel, input logic [7:0] wdat, input string tag);
        int exp_lat;
        int n;
        exp_lat = (!we && sel == 2'd3) ? 2 : 1;
        if (we) begin
            case (sel)
                2'd0: m_pel = wdat;
                2'd1: begin m_rd_reg = wdat; m_rd_cyc = 2'd0; m_state = 2'b11; end
                2'd2: begin m_wr_reg = wdat; m_wr_cyc = 2'd0; m_state = 2'b00; end
                default: begin
                    wq.push_back('{r: m_wr_reg, c: m_wr_cyc, d: wdat[5:2]});
                    if (m_wr_cyc == 2'd2) begin m_wr_cyc = 2'd0; m_wr_reg = m_wr_reg + 8'h01; end
                    else m_wr_cyc = m_wr_cyc + 2'd1;
                end
            endcase
        end else begin
            case (sel)
                2'd0: rq.push_back(m_pel);
                2'd1: rq.push_back({6'b0, m_state});
                2'd2: rq.push_back(m_wr_reg);
                default: begin
                    rq.push_back({2'b00, pal_val(m_rd_reg, m_rd_cyc), 2'b00});
                    if (m_rd_cyc == 2'd2) begin m_rd_cyc = 2'd0; m_rd_reg = m_rd_reg + 8'h01; end
                    else m_rd_cyc = m_rd_cyc + 2'd1;
                end
            endcase
        end
        @(posedge clk);
        #1;
        io_stb  = 1'b1;
        io_we   = we;
        io_sel  = sel;
        io_wdat = wdat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!io_ack && n < 10);
        check({tag, "_ack"}, io_ack, 1);
        check({tag, "_lat"}, n - 1, exp_lat);
        if (!we) check({tag, "_rdat"}, io_rdat, rq.pop_front());
        io_stb = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},  io_ack,   0);
        check({tag, "_pel"},  pel_mask, 8'hFF);
        check({tag, "_we"},   dac_we,   0);
        check({tag, "_rdat"}, io_rdat,  0);
        check({tag, "_wreg"}, dac_write_data_register, 0);
        check({tag, "_wcyc"}, dac_write_data_cycle,    0);
        check({tag, "_rreg"}, dac_read_data_register,  0);
        check({tag, "_rcyc"}, dac_read_data_cycle,     0);
        check({tag, "_wdat"}, dac_write_data,          0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; io_stb = 1'b0; io_we = 1'b0; io_sel = 2'd0; io_wdat = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1; rst = 1'b0;

        // 1: reset values through the bus
        access(1'b0, 2'd0, 8'h00, "t1_3c6");
        access(1'b0, 2'd1, 8'h00, "t1_3c7");
        access(1'b0, 2'd2, 8'h00, "t1_3c8");

        // 2: one full R,G,B triple then index readback
        access(1'b1, 2'd2, 8'h10, "t2_idx");
        access(1'b1, 2'd3, 8'h3F, "t2_r");
        access(1'b1, 2'd3, 8'h20, "t2_g");
        access(1'b1, 2'd3, 8'h04, "t2_b");
        access(1'b0, 2'd2, 8'h00, "t2_3c8");

        // 3: index wrap FFh -> 00h
        access(1'b1, 2'd2, 8'hFF, "t3_idx");
        for (int i = 0; i < 4; i++) access(1'b1, 2'd3, 8'(8'h11 * (i + 1)), "t3_wr");
        access(1'b0, 2'd2, 8'h00, "t3_3c8");

        // 4: read sequence from index 05h
        access(1'b1, 2'd1, 8'h05, "t4_idx");
        for (int i = 0; i < 3; i++) access(1'b0, 2'd3, 8'h00, "t4_rd");
        access(1'b0, 2'd1, 8'h00, "t4_3c7");
        access(1'b1, 2'd0, 8'h5A, "t4_pelw");
        access(1'b0, 2'd0, 8'h00, "t4_pelr");

        // 5: interleaved read and write sequences stay independent
        access(1'b1, 2'd2, 8'h01, "t5_widx");
        access(1'b1, 2'd3, 8'h2C, "t5_wr0");
        access(1'b1, 2'd1, 8'h02, "t5_ridx");
        access(1'b0, 2'd3, 8'h00, "t5_rd0");
        access(1'b1, 2'd3, 8'h18, "t5_wr1");
        access(1'b0, 2'd1, 8'h00, "t5_3c7");

        // 6: reset during RD_WAIT
        @(posedge clk); #1;
        io_stb = 1'b1; io_we = 1'b0; io_sel = 2'd3;
        @(posedge clk); #1;
        rst = 1'b1; io_stb = 1'b0;
        @(negedge clk);
        check("t6_noack_rdwait", io_ack, 0);
        @(negedge clk);
        check_reset_outputs("t6_rst");
        @(posedge clk); #1; rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_noack_after", io_ack, 0);
        end
        access(1'b0, 2'd0, 8'h00, "t6_pel");
        access(1'b1, 2'd3, 8'h3C, "t6_wr");

        repeat (3) @(posedge clk);
        check("wq_empty", wq.size(), 0);
        check("rq_empty", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
